// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: shared types and constants for the stopwatch controller.
//   sw_state_t : controller state (CLEAR / RUN / PAUSE)
//   BCD_W      : bits per BCD digit
//   BCD_MAX    : largest BCD digit value
package stopwatch_pkg;

  typedef enum logic [1:0] {
    SW_CLEAR = 2'd0,
    SW_RUN   = 2'd1,
    SW_PAUSE = 2'd2
  } sw_state_t;

  localparam int         BCD_W   = 4;
  localparam logic [3:0] BCD_MAX = 4'd9;

endpackage

// File: rtl/stopwatch_ctrl_bcd_digit.sv
// bcd_digit: one decade of the stopwatch time counter.
// Ports:
//   clk      in  clock
//   rst      in  synchronous active-high reset
//   inc_i    in  advance this digit by one this cycle
//   clr_i    in  force digit to 0 (wins over inc_i)
//   digit_o  out current BCD value
//   carry_o  out inc_i while digit is 9: the next digit must advance
module bcd_digit
  import stopwatch_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [BCD_W-1:0] digit_o,
  output logic             carry_o
);

  logic [BCD_W-1:0] digit_q, digit_d;

  assign carry_o = inc_i && (digit_q == BCD_MAX);

  always_comb begin
    digit_d = digit_q;
    if (clr_i)        digit_d = '0;
    else if (carry_o) digit_d = '0;
    else if (inc_i)   digit_d = digit_q + BCD_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) digit_q <= '0;
    else     digit_q <= digit_d;
  end

  assign digit_o = digit_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: stopwatch FSM + prescaler + NUM_DIGITS-digit BCD time counter.
// Optional feature macro: STOPWATCH_LAP_EN (lap_i toggles a display freeze).
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   start_i      pulse: start / resume (samples rate_sel_i)
//   rate_sel_i   0 = TICK_DIV cycles per count, 1 = FAST_DIV cycles per count
//   pause_i      pulse: pause
//   clear_i      pulse: back to CLEAR (count, prescaler, overflow, freeze zeroed)
//   lap_i        pulse: toggle lap freeze (ignored unless STOPWATCH_LAP_EN)
//   digits_o     BCD display value, digit 0 at [3:0]
//   running_o    in RUN
//   paused_o     in PAUSE
//   tick_o       one-cycle pulse on each count increment
//   overflow_o   sticky: counter wrapped from all 9s to 0
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int TICK_DIV   = 100000,
  parameter int FAST_DIV   = 10000
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start_i,
  input  logic                        rate_sel_i,
  input  logic                        pause_i,
  input  logic                        clear_i,
  input  logic                        lap_i,
  output logic [BCD_W*NUM_DIGITS-1:0] digits_o,
  output logic                        running_o,
  output logic                        paused_o,
  output logic                        tick_o,
  output logic                        overflow_o
);

  localparam int                PRE_W     = $clog2(TICK_DIV);
  localparam logic [PRE_W-1:0] TICK_LAST = PRE_W'(TICK_DIV - 1);
  localparam logic [PRE_W-1:0] FAST_LAST = PRE_W'(FAST_DIV - 1);

  sw_state_t        state_q, state_d;
  logic             rate_q, rate_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic             ovf_q, ovf_d;
  logic             cnt_inc, cnt_clr, top_carry;
  logic             tick;
  logic [PRE_W-1:0] cur_last, new_last;

  logic [NUM_DIGITS-1:0][BCD_W-1:0] cnt;

  assign cur_last = rate_q     ? FAST_LAST : TICK_LAST;
  assign new_last = rate_sel_i ? FAST_LAST : TICK_LAST;
  assign tick     = (state_q == SW_RUN) && (pre_q == cur_last);

  // Priority each cycle: clear > pause > start. A pause pulse also masks a
  // start pulse in CLEAR/PAUSE, where it otherwise has no effect.
  always_comb begin
    state_d = state_q;
    rate_d  = rate_q;
    pre_d   = pre_q;
    cnt_inc = 1'b0;
    cnt_clr = 1'b0;
    case (state_q)
      SW_CLEAR: begin
        if (!clear_i && !pause_i && start_i) begin
          state_d = SW_RUN;
          rate_d  = rate_sel_i;
          pre_d   = '0;
        end
      end
      SW_RUN: begin
        if (clear_i) begin
          state_d = SW_CLEAR;
          pre_d   = '0;
          cnt_clr = 1'b1;
        end else if (pause_i) begin
          // pause beats a coincident tick; prescaler frozen where it is
          state_d = SW_PAUSE;
        end else begin
          cnt_inc = tick;
          if (start_i) begin
            rate_d = rate_sel_i;
            pre_d  = '0;
          end else if (tick) begin
            pre_d = '0;
          end else begin
            pre_d = pre_q + PRE_W'(1);
          end
        end
      end
      SW_PAUSE: begin
        if (clear_i) begin
          state_d = SW_CLEAR;
          pre_d   = '0;
          cnt_clr = 1'b1;
        end else if (!pause_i && start_i) begin
          state_d = SW_RUN;
          rate_d  = rate_sel_i;
          // a faster rate may leave the held phase at/after its last step
          if (pre_q >= new_last) pre_d = '0;
        end
      end
      default: begin
        state_d = SW_CLEAR;
        pre_d   = '0;
        cnt_clr = 1'b1;
      end
    endcase
  end

  always_comb begin
    ovf_d = ovf_q;
    if (cnt_clr)        ovf_d = 1'b0;
    else if (top_carry) ovf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SW_CLEAR;
      rate_q  <= 1'b0;
      pre_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rate_q  <= rate_d;
      pre_q   <= pre_d;
      ovf_q   <= ovf_d;
    end
  end

  // Ripple carry: each digit advances when the one below is 9 and advancing.
  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_dig
    logic inc, carry;
    if (k == 0) begin : g_lsd
      assign inc = cnt_inc;
    end else begin : g_up
      assign inc = g_dig[k-1].carry;
    end
    bcd_digit u_digit (
      .clk     (clk),
      .rst     (rst),
      .inc_i   (inc),
      .clr_i   (cnt_clr),
      .digit_o (cnt[k]),
      .carry_o (carry)
    );
  end

  assign top_carry = g_dig[NUM_DIGITS-1].carry;

`ifdef STOPWATCH_LAP_EN
  logic                        frz_q, frz_d;
  logic [BCD_W*NUM_DIGITS-1:0] lap_q, lap_d;
  logic                        lap_ev;

  assign lap_ev = lap_i && !clear_i && (state_q != SW_CLEAR);

  always_comb begin
    frz_d = frz_q;
    lap_d = lap_q;
    if (cnt_clr) begin
      frz_d = 1'b0;
      lap_d = '0;
    end else if (lap_ev) begin
      frz_d = !frz_q;
      if (!frz_q) lap_d = cnt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      frz_q <= 1'b0;
      lap_q <= '0;
    end else begin
      frz_q <= frz_d;
      lap_q <= lap_d;
    end
  end

  assign digits_o = frz_q ? lap_q : cnt;
`else
  logic unused_lap;
  assign unused_lap = lap_i;
  assign digits_o   = cnt;
`endif

  assign running_o  = (state_q == SW_RUN);
  assign paused_o   = (state_q == SW_PAUSE);
  assign tick_o     = tick;
  assign overflow_o = ovf_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
module tb_stopwatch_ctrl;

  localparam int ND   = 2;
  localparam int TD   = 4;
  localparam int FD   = 2;
  localparam int MODV = 100;  // 10**ND

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start_i = 1'b0, rate_sel_i = 1'b0, pause_i = 1'b0, clear_i = 1'b0, lap_i = 1'b0;
  logic [4*ND-1:0] digits_o;
  logic running_o, paused_o, tick_o, overflow_o;

  stopwatch_ctrl #(.NUM_DIGITS(ND), .TICK_DIV(TD), .FAST_DIV(FD)) dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start_i),
    .rate_sel_i (rate_sel_i),
    .pause_i    (pause_i),
    .clear_i    (clear_i),
    .lap_i      (lap_i),
    .digits_o   (digits_o),
    .running_o  (running_o),
    .paused_o   (paused_o),
    .tick_o     (tick_o),
    .overflow_o (overflow_o)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;
  bit chk_en = 1'b0;

  // Reference model: state 0=clear 1=run 2=pause, count held as a plain integer.
  int m_st = 0, m_rate = 0, m_pre = 0, m_cnt = 0, m_lapv = 0;
  bit m_ovf = 1'b0, m_frz = 1'b0;

  function automatic int lim(int r);
    return (r != 0) ? FD : TD;
  endfunction

  function automatic logic [4*ND-1:0] to_bcd(int v);
    logic [4*ND-1:0] r;
    int x;
    r = '0;
    x = v;
    for (int i = 0; i < ND; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic bit m_tick();
    return (m_st == 1) && (m_pre == lim(m_rate) - 1);
  endfunction

  always @(posedge clk) begin : model
    bit tk;
    if (rst) begin
      m_st = 0; m_rate = 0; m_pre = 0; m_cnt = 0; m_lapv = 0; m_ovf = 0; m_frz = 0;
    end else begin
      tk = m_tick();
`ifdef STOPWATCH_LAP_EN
      if (lap_i && !clear_i && m_st != 0) begin
        if (!m_frz) m_lapv = m_cnt;
        m_frz = !m_frz;
      end
`endif
      if (clear_i) begin
        m_st = 0; m_cnt = 0; m_pre = 0; m_ovf = 0; m_frz = 0; m_lapv = 0;
      end else if (pause_i) begin
        if (m_st == 1) m_st = 2;
      end else if (m_st == 1) begin
        if (tk) begin
          m_cnt = m_cnt + 1;
          if (m_cnt == MODV) begin m_cnt = 0; m_ovf = 1; end
        end
        if (start_i) begin m_rate = rate_sel_i; m_pre = 0; end
        else m_pre = tk ? 0 : m_pre + 1;
      end else if (start_i) begin
        m_rate = rate_sel_i;
        if (m_st == 0 || m_pre >= lim(m_rate) - 1) m_pre = 0;
        m_st = 1;
      end
    end
  end

  always @(negedge clk) begin
    logic [4*ND-1:0] exp_d;
    if (chk_en) begin
      exp_d = m_frz ? to_bcd(m_lapv) : to_bcd(m_cnt);
      nvec++;
      if (digits_o !== exp_d || running_o !== (m_st == 1) || paused_o !== (m_st == 2) ||
          tick_o !== m_tick() || overflow_o !== m_ovf) begin
        nerr++;
        $display("FAIL cycle_check t=%0t: dig %h want %h run %b want %b pau %b want %b tick %b want %b ovf %b want %b",
                 $time, digits_o, exp_d, running_o, m_st == 1, paused_o, m_st == 2,
                 tick_o, m_tick(), overflow_o, m_ovf);
      end
    end
  end

  task automatic step(int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic wait_digits(logic [4*ND-1:0] v, int bound);
    int n;
    n = 0;
    while (digits_o !== v && n < bound) begin step(1); n++; end
    nvec++;
    if (digits_o !== v) begin
      nerr++;
      $display("FAIL wait_digits: got %h want %h", digits_o, v);
    end
  endtask

  task automatic wait_ticks(int k, int bound);
    int n, seen;
    n = 0; seen = 0;
    while (seen < k && n < bound) begin
      if (tick_o === 1'b1) seen++;
      if (seen < k) begin step(1); n++; end
    end
    nvec++;
    if (seen != k) begin
      nerr++;
      $display("FAIL wait_ticks: got %0d want %0d", seen, k);
    end
  endtask

  task automatic pulse_start(logic rate);
    rate_sel_i = rate; start_i = 1'b1;
    step(1);
    start_i = 1'b0; rate_sel_i = 1'b0;
  endtask

  task automatic pulse_clear();
    clear_i = 1'b1; step(1); clear_i = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation timed out");
    $fatal(1, "timeout");
  end

  initial begin
    // reset
    @(posedge clk); #1;
    chk_en = 1'b1;
    rst = 1'b0;
    check("rst_digits", 32'(digits_o), 32'h00);
    check("rst_running", 32'(running_o), 0);
    check("rst_paused", 32'(paused_o), 0);
    check("rst_tick", 32'(tick_o), 0);
    check("rst_ovf", 32'(overflow_o), 0);
    step(2);
    check("idle_digits", 32'(digits_o), 32'h00);

    // normal rate: start in cycle 0, ticks at 4, 8, ..., 40
    pulse_start(1'b0);                      // cycle 1
    check("run_after_start", 32'(running_o), 1);
    check("no_tick_c1", 32'(tick_o), 0);
    step(3);                                // cycle 4
    check("first_tick_c4", 32'(tick_o), 1);
    step(1);
    check("digits_one", 32'(digits_o), 32'h01);
    step(35);                               // cycle 40
    check("tick_c40", 32'(tick_o), 1);
    step(1);
    check("digits_ten", 32'(digits_o), 32'h10);

    // wrap from 99
    wait_digits(8'h99, 400);
    wait_ticks(1, 8);
    step(1);
    check("wrap_digits", 32'(digits_o), 32'h00);
    check("wrap_ovf", 32'(overflow_o), 1);
    check("wrap_running", 32'(running_o), 1);
    pulse_clear();
    check("clr_ovf", 32'(overflow_o), 0);
    check("clr_digits", 32'(digits_o), 32'h00);
    check("clr_running", 32'(running_o), 0);

    // pause at pre=2, resume 3 cycles later: prescaler phase retained
    pulse_start(1'b0);                      // S+1, pre 0
    step(2);                                // S+3, pre 2
    pause_i = 1'b1; step(1); pause_i = 1'b0;
    check("paused", 32'(paused_o), 1);
    check("paused_not_run", 32'(running_o), 0);
    step(2);                                // S+6
    pulse_start(1'b0);                      // S+7, pre 2
    check("resume_no_tick", 32'(tick_o), 0);
    step(1);
    check("resume_tick", 32'(tick_o), 1);
    step(1);
    check("resume_digits", 32'(digits_o), 32'h01);

    // pause + clear together -> CLEAR; then fast rate, period 2
    pause_i = 1'b1; clear_i = 1'b1; step(1); pause_i = 1'b0; clear_i = 1'b0;
    check("pc_running", 32'(running_o), 0);
    check("pc_paused", 32'(paused_o), 0);
    check("pc_digits", 32'(digits_o), 32'h00);
    pulse_start(1'b1);                      // S+1
    step(1);
    check("fast_tick1", 32'(tick_o), 1);
    step(1);
    check("fast_gap", 32'(tick_o), 0);
    check("fast_digits", 32'(digits_o), 32'h01);
    step(1);
    check("fast_tick2", 32'(tick_o), 1);

    // start while running restarts the prescaler at the new rate
    step(1);                                // pre 0, no tick
    pulse_start(1'b0);                      // R+1
    step(2);                                // R+3
    check("restart_no_tick", 32'(tick_o), 0);
    step(1);
    check("restart_tick", 32'(tick_o), 1);
    step(2);                                // pre 1
    pause_i = 1'b1; step(1); pause_i = 1'b0;
    pulse_start(1'b1);                      // pre 1 >= FD-1 -> cleared
    check("ratechg_no_tick", 32'(tick_o), 0);
    step(1);
    check("ratechg_tick", 32'(tick_o), 1);

    // mixed pulses, checked every cycle against the model
    for (int i = 0; i < 400; i++) begin
      int r;
      r = $urandom_range(0, 99);
      start_i    = (r < 8) || (r == 14);
      pause_i    = (r >= 8 && r < 13) || (r == 14);
      clear_i    = (r == 13);
      lap_i      = (r >= 90 && r < 94);
      rate_sel_i = 1'($urandom_range(0, 1));
      step(1);
    end
    start_i = 0; pause_i = 0; clear_i = 0; lap_i = 0; rate_sel_i = 0;

`ifdef STOPWATCH_LAP_EN
    pulse_clear();
    pulse_start(1'b0);
    wait_digits(8'h05, 40);
    lap_i = 1'b1; step(1); lap_i = 1'b0;
    wait_ticks(8, 60);
    step(1);
    check("lap_frozen", 32'(digits_o), 32'h05);
    lap_i = 1'b1; step(1); lap_i = 1'b0;
    check("lap_release", 32'(digits_o), 32'h13);
`endif

    step(2);
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
